// File: rtl/kernel2_mul_rr_sched.sv
// Round-robin front end sharing one pipelined unsigned AW x BW multiplier among NUM_REQ requesters.
// Results leave on a single valid/ready port tagged with the issuing requester index.
module kernel2_mul_rr_sched #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_STAGE = 3,
    parameter int AW        = 13,
    parameter int BW        = 11,
    parameter int IDW       = 3
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*AW-1:0]  req_a,
    input  logic [NUM_REQ*BW-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [AW+BW-1:0]       rsp_p,
    output logic                   busy
);

    localparam int PW   = AW + BW;
    localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTRW-1:0]      rr_ptr;
    logic                 adv;
    logic                 grant_any;
    logic                 transfer;
    logic [PTRW-1:0]      winner;
    logic [AW-1:0]        win_a;
    logic [BW-1:0]        win_b;
    logic [NUM_STAGE-1:0] vld_q;
    logic [IDW-1:0]       id_q [NUM_STAGE];

    assign adv      = !rsp_valid || rsp_ready;
    assign transfer = grant_any && adv;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : p_arb
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                winner    = PTRW'(idx);
            end
        end
    end

    // Reset gates the grant so no requester sees ready while the pipeline is being cleared.
    always_comb begin
        req_ready = '0;
        if (grant_any && adv && ap_rst_n) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign win_a = req_a[winner*AW +: AW];
    assign win_b = req_b[winner*BW +: BW];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            if (winner == PTRW'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= winner + PTRW'(1);
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                id_q[i] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= transfer;
            if (transfer) begin
                id_q[0] <= IDW'(winner);
            end
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_one
            logic [PW-1:0] p_q;

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    p_q <= '0;
                end else if (transfer) begin
                    p_q <= PW'(win_a) * PW'(win_b);
                end
            end

            assign rsp_p = p_q;
        end else begin : g_multi
            // Operands are registered ahead of the multiply so the product maps onto a DSP with input registers.
            logic [AW-1:0] a_q;
            logic [BW-1:0] b_q;
            logic [PW-1:0] p_q [1:NUM_STAGE-1];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    for (int i = 1; i < NUM_STAGE; i++) begin
                        p_q[i] <= '0;
                    end
                end else if (adv) begin
                    if (transfer) begin
                        a_q <= win_a;
                        b_q <= win_b;
                    end
                    p_q[1] <= PW'(a_q) * PW'(b_q);
                    for (int i = 2; i < NUM_STAGE; i++) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
            end

            assign rsp_p = p_q[NUM_STAGE-1];
        end
    endgenerate

    assign rsp_valid = vld_q[NUM_STAGE-1];
    assign rsp_id    = id_q[NUM_STAGE-1];
    assign busy      = |vld_q;

endmodule
